// File: rtl/uart_bridge.sv
// Host-bus to serial UART bridge: 8N1 receiver and transmitter, CLK_DIV clocks per bit.
// Optional macro UART_RX_FIFO_EN turns the single RX holding register into a 4-entry FIFO.
module uart_bridge #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] UartData,
    input  logic       rdn,
    input  logic       wrn,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    input  logic       rxd,
    output logic       txd
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    rx_state_t   rx_state_q;
    tx_state_t   tx_state_q;
    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [15:0] rx_cnt_q, tx_cnt_q;
    logic [2:0]  rx_bit_q, tx_bit_q;
    logic [7:0]  rx_shift_q, tx_shift_q, hold_q, wr_data_q, rd_byte_s;
    logic        rx_commit_q, rd_arm_q, rd_done_s, wrn_prev_q, wr_commit_s;
    logic        data_ready_q, tbre_q, tsre_q, txd_q;

    assign data_ready  = data_ready_q;
    assign tbre        = tbre_q;
    assign tsre        = tsre_q;
    assign txd         = txd_q;
    assign rd_done_s   = rd_arm_q && rdn;
    assign wr_commit_s = !wrn_prev_q && wrn;
    assign UartData    = (rst && !rdn && wrn) ? rd_byte_s : 8'hzz;

    // rxd synchronizer with one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // RX frame FSM; rx_commit_q pulses for one cycle with a good byte in rx_shift_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_commit_q <= 1'b0;
        end else begin
            rx_commit_q <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    rx_cnt_q <= 16'd0;
                    if (rxd_prev_q && !rxd_sync_q) rx_state_q <= R_START;
                end
                R_START: begin
                    if (rx_cnt_q == DIV_HALF) begin
                        rx_cnt_q   <= 16'd0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rxd_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= 16'd0;
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q    <= 16'd0;
                        rx_state_q  <= R_IDLE;
                        rx_commit_q <= rxd_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    // a read is armed by a cycle of rdn=0/wrn=1 and completes when rdn is seen high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_arm_q <= 1'b0;
        else      rd_arm_q <= !rdn && wrn;
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q, count_d;
    logic       push_s, pop_s;

    // pop is evaluated first so a full FIFO can accept a byte in the cycle it is read
    always_comb begin
        pop_s   = rd_done_s && (count_q != 3'd0);
        push_s  = rx_commit_q && ((count_q != 3'd4) || pop_s);
        count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
    end

    assign rd_byte_s = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : fifo_q[rd_ptr_q - 2'd1];

    // RX FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 8'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            data_ready_q <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= rx_shift_q;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q      <= count_d;
            data_ready_q <= (count_d != 3'd0);
        end
    end
`else
    logic [7:0] rx_hold_q;

    assign rd_byte_s = rx_hold_q;

    // single RX holding register; a new byte overwrites an unread one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_hold_q    <= 8'd0;
            data_ready_q <= 1'b0;
        end else if (rx_commit_q) begin
            rx_hold_q    <= rx_shift_q;
            data_ready_q <= 1'b1;
        end else if (rd_done_s) begin
            data_ready_q <= 1'b0;
        end
    end
`endif

    // host write capture, holding register and TX frame FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrn_prev_q <= 1'b1;
            wr_data_q  <= 8'd0;
            hold_q     <= 8'd0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
        end else begin
            wrn_prev_q <= wrn;
            if (!wrn) wr_data_q <= UartData;
            if (wr_commit_s && tbre_q) begin
                hold_q <= wr_data_q;
                tbre_q <= 1'b0;
            end
            case (tx_state_q)
                T_IDLE: begin
                    tx_cnt_q <= 16'd0;
                    if (!tbre_q) begin
                        tx_shift_q <= hold_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_state_q <= T_START;
                    end
                end
                T_START: begin
                    if (tx_cnt_q == DIV_LAST) begin
                        tx_cnt_q   <= 16'd0;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= T_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                T_DATA: begin
                    if (tx_cnt_q == DIV_LAST) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= T_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                T_STOP: begin
                    if (tx_cnt_q == DIV_LAST) begin
                        tx_cnt_q <= 16'd0;
                        if (!tbre_q) begin
                            tx_shift_q <= hold_q;
                            tbre_q     <= 1'b1;
                            txd_q      <= 1'b0;
                            tx_state_q <= T_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= T_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge at CLK_DIV=16; a pull-up makes an undriven bus read as 8'hFF.
module tb_uart_bridge;
    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic       data_ready, tbre, tsre, txd;
    logic [7:0] host_bus = 8'h00;
    logic       host_drv = 1'b0;
    logic [7:0] rd_val;
    wire  [7:0] UartData;
    int         total = 0;
    int         bad = 0;

    assign UartData = host_drv ? host_bus : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (UartData[g]);
    end

    uart_bridge #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .UartData(UartData), .rdn(rdn), .wrn(wrn),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic host_write(input logic [7:0] b);
        @(negedge clk);
        host_bus = b;
        host_drv = 1'b1;
        wrn      = 1'b0;
        @(negedge clk);
        wrn      = 1'b1;
        host_drv = 1'b0;
    endtask

    task automatic host_read(output logic [7:0] d);
        @(negedge clk) rdn = 1'b0;
        @(negedge clk);
        d   = UartData;
        rdn = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // called half a cycle after the start bit began; lead cycles reach mid start bit
    task automatic tx_frame(input logic [7:0] b, input int lead);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        repeat (lead) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("txbit%0d_%h", i, b), txd, f[i]);
            chk1("tsre_busy", tsre, 1'b0);
            if (i < 9) repeat (DIV) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk1("rst_data_ready", data_ready, 1'b0);
        chk1("rst_tbre", tbre, 1'b1);
        chk1("rst_tsre", tsre, 1'b1);
        chk1("rst_txd", txd, 1'b1);
        rdn = 1'b0;
        #1 chk8("rst_bus_undriven", UartData, 8'hFF);
        rdn = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);

        // receive 0xA5, read it, then read again with nothing pending
        send_rx(8'hA5, 1'b1);
        @(negedge clk);
        chk1("rx_a5_ready", data_ready, 1'b1);
        host_read(rd_val);
        chk8("rx_a5_data", rd_val, 8'hA5);
        chk1("rx_a5_consumed", data_ready, 1'b0);
        host_read(rd_val);
        chk8("rx_empty_read_last", rd_val, 8'hA5);
        chk1("rx_empty_still_empty", data_ready, 1'b0);

        // glitch and framing error are both discarded
        @(negedge clk) rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk1("rx_glitch_no_byte", data_ready, 1'b0);
        send_rx(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        chk1("rx_frame_err_no_byte", data_ready, 1'b0);

        // three unread frames
        send_rx(8'h01, 1'b1);
        send_rx(8'h02, 1'b1);
        send_rx(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        chk1("rx3_ready", data_ready, 1'b1);
`ifdef UART_RX_FIFO_EN
        host_read(rd_val);
        chk8("fifo_rd0", rd_val, 8'h01);
        host_read(rd_val);
        chk8("fifo_rd1", rd_val, 8'h02);
        host_read(rd_val);
        chk8("fifo_rd2", rd_val, 8'h03);
`else
        host_read(rd_val);
        chk8("overrun_last_wins", rd_val, 8'h03);
`endif
        chk1("rx3_drained", data_ready, 1'b0);

        // single transmit of 0x3C
        host_write(8'h3C);
        @(negedge clk) chk1("tx3c_tbre_full", tbre, 1'b0);
        @(negedge clk);
        chk1("tx3c_tbre_empty", tbre, 1'b1);
        chk1("tx3c_tsre_busy", tsre, 1'b0);
        chk1("tx3c_start", txd, 1'b0);
        tx_frame(8'h3C, 8);
        repeat (8) @(negedge clk);
        chk1("tx3c_tsre_idle", tsre, 1'b1);
        chk1("tx3c_txd_idle", txd, 1'b1);

        // back-to-back 0x12/0x34, dropped 0x56, and a simultaneous rdn/wrn cycle
        host_write(8'h12);
        @(negedge clk);
        @(negedge clk);
        chk1("tx12_start", txd, 1'b0);
        host_write(8'h34);
        @(negedge clk) chk1("tx34_held", tbre, 1'b0);
        host_write(8'h56);
        @(negedge clk) chk1("tx56_busy_tbre", tbre, 1'b0);
        rdn = 1'b0;
        wrn = 1'b0;
        @(negedge clk);
        chk8("rdwr_bus_undriven", UartData, 8'hFF);
        rdn = 1'b1;
        wrn = 1'b1;
        tx_frame(8'h12, 1);
        repeat (8) @(negedge clk);
        chk1("b2b_start", txd, 1'b0);
        chk1("b2b_tsre", tsre, 1'b0);
        chk1("b2b_tbre", tbre, 1'b1);
        tx_frame(8'h34, 8);
        repeat (8) @(negedge clk);
        chk1("b2b_tsre_idle", tsre, 1'b1);
        chk1("b2b_no_third", txd, 1'b1);
        chk1("rdwr_no_consume", data_ready, 1'b0);

        // reset in the middle of data bit 4 of 0xC3, then a fresh frame
        host_write(8'hC3);
        @(negedge clk);
        @(negedge clk);
        repeat (8 + DIV * 5) @(negedge clk);
        chk1("txc3_bit4", txd, 1'b0);
        rst = 1'b0;
        #1;
        chk1("midrst_txd", txd, 1'b1);
        chk1("midrst_tsre", tsre, 1'b1);
        chk1("midrst_tbre", tbre, 1'b1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        host_write(8'h7E);
        @(negedge clk) chk1("tx7e_tbre_full", tbre, 1'b0);
        @(negedge clk) chk1("tx7e_start", txd, 1'b0);
        tx_frame(8'h7E, 8);
        repeat (8) @(negedge clk);
        chk1("tx7e_tsre_idle", tsre, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 Parameter CLK_DIV, default 434, clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 UartData  inout  8  parallel data bus; driven only during a host read, else Z.
REQ-005 rdn  input  1  host read strobe, active-low.
REQ-006 wrn  input  1  host write strobe, active-low.
REQ-007 data_ready  output  1  1 = received byte available.
REQ-008 tbre  output  1  1 = transmit holding register empty.
REQ-009 tsre  output  1  1 = transmit shift register idle.
REQ-010 rxd  input  1  serial input, idle high, asynchronous to clk.
REQ-011 txd  output  1  serial output, idle high.

Function
REQ-012 rxd SHALL pass a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-013 RX FSM states: R_IDLE, R_START, R_DATA, R_STOP; single bit counter 0..CLK_DIV-1, bit index 0..7.
REQ-014 R_IDLE -> R_START on synchronized 1->0; at count CLK_DIV/2 (integer) sample: 0 -> R_DATA, 1 -> R_IDLE (glitch, discarded).
REQ-015 R_DATA SHALL sample every CLK_DIV cycles at mid-bit, LSB first, 8 bits, then -> R_STOP.
REQ-016 R_STOP samples mid-bit: 1 -> byte committed to RX storage, -> R_IDLE; 0 -> framing error, byte discarded, -> R_IDLE.
REQ-017 Host read: UartData SHALL be driven combinationally with the oldest RX byte while rdn=0 and wrn=1.
REQ-018 A read completes on the rdn 0->1 transition sampled at clk; the byte is consumed; data_ready updates on the following clk edge.
REQ-019 Read with data_ready=0: bus driven with last byte, nothing consumed, no error.
REQ-020 Commit and consume in the same cycle: consume applies to the old byte, the new byte remains, data_ready stays 1.
REQ-021 Host write: UartData captured every clk while wrn=0; committed to the holding register on the wrn 0->1 transition; tbre=0 on the next edge.
REQ-022 Write committed while tbre=0 SHALL be dropped; holding register unchanged.
REQ-023 rdn=0 and wrn=0 together: bus not driven, write proceeds, read neither drives nor consumes.
REQ-024 TX FSM states: T_IDLE, T_START, T_DATA, T_STOP; each bit lasts exactly CLK_DIV cycles.
REQ-025 T_IDLE with holding full: next edge moves byte to shifter, tbre=1, tsre=0, txd=0 (start).
REQ-026 Frame = start 0, 8 data bits LSB first, stop 1; tsre returns 1 at the end of the stop bit unless holding full, in which case the next frame starts back-to-back and tsre stays 0.
REQ-027 txd SHALL be registered (glitch-free).

Reset
REQ-028 rst=0: data_ready=0, tbre=1, tsre=1, txd=1, UartData=Z, both FSMs idle, counters 0, RX storage emptied, regardless of any frame in progress.
REQ-029 After release, the first rxd falling edge is accepted no earlier than 2 clks (synchronizer fill).

Configuration
REQ-030 Macro UART_RX_FIFO_EN defined: RX storage is a 4-entry FIFO; data_ready = not empty; byte committed while full is dropped and the FIFO unchanged.
REQ-031 UART_RX_FIFO_EN undefined: RX storage is a single holding register; byte committed while data_ready=1 overwrites it (overrun, last byte wins).

Verification (CLK_DIV=16)
REQ-032 rxd frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop 1 -> data_ready=1 ~160 clks after start edge; rdn pulse reads 0xA5; data_ready=0 after rdn rises.
REQ-033 Write 0x3C via wrn pulse -> tbre 0 then 1 next clk, tsre=0; txd = 0,0,0,1,1,1,1,0,0,1 each 16 clks; tsre=1 after 160 clks.
REQ-034 Two writes 0x12, 0x34 with the second after tbre=1 -> back-to-back frames, tsre low throughout 320 clks; third write while tbre=0 dropped.
REQ-035 rxd low for 4 clks only -> no byte, data_ready stays 0; frame 0x55 with stop=0 -> discarded.
REQ-036 Three frames 0x01,0x02,0x03 unread -> without macro read returns 0x03; with UART_RX_FIFO_EN reads return 0x01,0x02,0x03, then data_ready=0.
REQ-037 rst asserted mid-TX bit 4 -> txd=1, tsre=1, tbre=1 immediately; after release, new write 0x7E transmits a correct frame.
